// File: rtl/mvma_requant_out.sv
// mvma_requant_out: requantises 16-bit MAC results to 8-bit, buffers them in a FIFO and tags vector ends.
// Define MVMA_REQUANT_RELU_EN to zero negative outputs after the clamp.
module mvma_requant_out #(
   parameter int VEC_LEN = 4,
   parameter int SHIFT   = 4,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic signed [15:0] data_in,
   input  logic               ovf_in,
   output logic               m_valid,
   input  logic               m_ready,
   output logic signed [7:0]  data_out,
   output logic               m_last,
   output logic               m_ovf
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = VEC_LEN > 1 ? $clog2(VEC_LEN) : 1;
   logic [9:0]         mem [DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [AW:0]        count;
   logic [CW-1:0]      elem_cnt;
   logic               vec_ovf, push, pop, last;
   logic signed [15:0] sh;
   logic signed [7:0]  qc, q;
   logic [9:0]         head;
   always_comb begin
      sh = data_in >>> SHIFT;
      qc = sh > 16'sd127 ? 8'sd127 : sh < -16'sd128 ? -8'sd128 : sh[7:0];
`ifdef MVMA_REQUANT_RELU_EN
      q = qc[7] ? 8'sd0 : qc;
`else
      q = qc;
`endif
      s_ready = count != (AW+1)'(DEPTH);
      m_valid = count != '0;
      push = s_valid && s_ready;
      pop = m_valid && m_ready;
      last = elem_cnt == CW'(VEC_LEN - 1);
      head = m_valid ? mem[rd_ptr] : 10'd0;
      data_out = head[9:2];
      m_last = head[1];
      m_ovf = head[0];
   end
   // Storage has no reset; emptiness is tracked by count alone.
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {q, last, last & (vec_ovf | ovf_in)};
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         elem_cnt <= '0;
         vec_ovf <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
         if (push) begin
            elem_cnt <= last ? '0 : elem_cnt + 1'b1;
            vec_ovf <= last ? 1'b0 : (vec_ovf | ovf_in);
         end
      end
   end
endmodule

// File: tb/tb_mvma_requant_out.sv
// tb_mvma_requant_out: directed and random stimulus against a queue-based scoreboard model.
module tb_mvma_requant_out;
   localparam int VEC_LEN = 4, SHIFT = 4, DEPTH = 4;
   logic clk = 0, reset = 1, s_valid = 0, ovf_in = 0, m_ready = 0;
   logic s_ready, m_valid, m_last, m_ovf;
   logic signed [15:0] data_in = 0;
   logic signed [7:0] data_out;
   int tests = 0, fails = 0, mcnt = 0, pushed = 0;
   logic mvov = 0, stalled = 0;
   logic [9:0] held, e;
   logic [9:0] exp_q[$];

   always #5 clk = ~clk;

   mvma_requant_out #(.VEC_LEN(VEC_LEN), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .data_in(data_in),
      .ovf_in(ovf_in), .m_valid(m_valid), .m_ready(m_ready), .data_out(data_out),
      .m_last(m_last), .m_ovf(m_ovf));

   function automatic logic [7:0] req(input int v);
      int m, f;
      m = 1 << SHIFT;
      f = (v - (((v % m) + m) % m)) / m;
      if (f > 127) f = 127;
      if (f < -128) f = -128;
`ifdef MVMA_REQUANT_RELU_EN
      if (f < 0) f = 0;
`endif
      return 8'(f);
   endfunction

   task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic sv, input logic signed [15:0] d, input logic ov, input logic mr);
      int n;
      logic full, lst;
      s_valid = sv; data_in = d; ovf_in = ov; m_ready = mr;
      #1;
      n = exp_q.size();
      full = n >= DEPTH;
      chk("s_ready", 10'(s_ready), 10'(!full));
      chk("m_valid", 10'(m_valid), 10'(n != 0));
      if (stalled && n != 0) chk("hold", {data_out, m_last, m_ovf}, held);
      if (n == 0) chk("idle_out", {data_out, m_last, m_ovf}, 10'd0);
      else if (mr) begin
         e = exp_q.pop_front();
         chk("elem", {data_out, m_last, m_ovf}, e);
      end
      stalled = !mr && n != 0;
      held = {data_out, m_last, m_ovf};
      if (sv && !full) begin
         lst = mcnt == VEC_LEN - 1;
         exp_q.push_back({req(int'(d)), lst, lst & (mvov | ov)});
         mvov = lst ? 1'b0 : (mvov | ov);
         mcnt = lst ? 0 : mcnt + 1;
         pushed++;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1; s_valid = 0; m_ready = 0;
      @(posedge clk); #1;
      reset = 0;
      exp_q.delete(); mcnt = 0; mvov = 0; stalled = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < 3 * DEPTH && exp_q.size() != 0; i++) cyc(0, 0, 0, 1);
      chk("drained", 10'(exp_q.size()), 10'd0);
   endtask

   initial begin
      int target;
      logic signed [15:0] t1 [4] = '{16'sd100, -16'sd100, 16'sd3000, -16'sd4000};
      @(posedge clk); #1;
      do_reset();
      cyc(0, 0, 0, 0);
      // arithmetic: expect 6, -7, 127, -128
      for (int i = 0; i < 4; i++) cyc(1, t1[i], 0, 1);
      drain();
      // vector tagging, overflow on element 2 of the first vector only
      for (int i = 1; i <= 8; i++) cyc(1, 16'(i * 37 - 150), i == 2, 1);
      drain();
      // fill under backpressure, then release
      for (int i = 0; i < 6; i++) cyc(1, 16'(i * 500 - 1200), 0, 0);
      drain();
      // full-rate streaming
      for (int i = 0; i < 20; i++) cyc(1, 16'(i * 1111 - 9000), i == 5, 1);
      drain();
      // random bursts
      target = pushed + 1000;
      for (int i = 0; i < 20000 && pushed < target; i++)
         cyc(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
      chk("rand_pushed", 10'(pushed >= target), 10'd1);
      drain();
      // reset with a partial vector queued
      for (int i = 0; i < 4; i++) cyc(1, 16'(i * 64), 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
      cyc(1, 16'sd320, 1, 0);
      cyc(1, 16'sd640, 0, 0);
      chk("pre_reset_depth", 10'(exp_q.size()), 10'd3);
      do_reset();
      cyc(0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(1, 16'(i * 16 + 16), i == 0, 1);
      drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
